// File: rtl/tree_pkg.sv
// Shared types and helpers for the hierarchy-node fan-in path.
package tree_pkg;

  localparam int DEFAULT_NUM_CHILD = 5;
  localparam int DEFAULT_IDX_W     = 3;

  typedef logic [DEFAULT_IDX_W-1:0] child_idx_t;

  // Successor of idx in a ring of n positions.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tree_fanin_collector_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter
  import tree_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_CHILD,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tree_fanin_collector.sv
// Merges NUM_CHILD child streams into one registered upstream stream,
// tagging each beat with its source child and counting delivered beats.
module tree_fanin_collector
  import tree_pkg::*;
#(
  parameter int NUM_CHILD = DEFAULT_NUM_CHILD,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = DEFAULT_IDX_W,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        up_valid,
  input  logic                        up_ready,
  output logic [DATA_W-1:0]           up_data,
  output logic [IDX_W-1:0]            up_idx,
  output logic [CNT_W-1:0]            beat_cnt
);

  logic                 up_valid_q, up_valid_d;
  logic [DATA_W-1:0]    up_data_q, up_data_d;
  logic [IDX_W-1:0]     up_idx_q, up_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [NUM_CHILD-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 out_free;
  logic                 child_hs;
  logic                 up_hs;

  rr_arbiter #(
    .N     (NUM_CHILD),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (child_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign out_free = !up_valid_q || up_ready;
  assign up_hs    = up_valid_q && up_ready;
  assign child_hs = gnt_any && out_free && rst_n;

  // rst_n gating keeps ready low during reset even though grant is combinational.
  assign child_ready = (rst_n && out_free) ? gnt : '0;

  always_comb begin
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_idx_d   = up_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;

    if (child_hs) begin
      up_valid_d = 1'b1;
      up_data_d  = child_data[gnt_idx*DATA_W +: DATA_W];
      up_idx_d   = gnt_idx;
      rr_ptr_d   = IDX_W'(rr_next(int'(gnt_idx), NUM_CHILD));
    end else if (up_hs) begin
      up_valid_d = 1'b0;
    end

    if (up_hs && (beat_cnt_q != {CNT_W{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_idx_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_idx_q   <= up_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign up_valid = up_valid_q;
  assign up_data  = up_data_q;
  assign up_idx   = up_idx_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_tree_fanin_collector.sv
// Directed bench for tree_fanin_collector: arbitration order, stall, counter saturation, reset.
module tb_tree_fanin_collector;

  localparam int NC = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic              clk;
  logic              rst_n;
  logic [NC-1:0]     child_valid;
  logic [NC*DW-1:0]  child_data;
  logic [NC-1:0]     child_ready, child_ready4;
  logic              up_valid, up_valid4;
  logic              up_ready;
  logic [DW-1:0]     up_data, up_data4;
  logic [IW-1:0]     up_idx, up_idx4;
  logic [15:0]       beat_cnt;
  logic [3:0]        beat_cnt4;

  int n_cmp = 0;
  int n_mis = 0;

  tree_fanin_collector #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready), .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .up_idx(up_idx), .beat_cnt(beat_cnt));

  tree_fanin_collector #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .child_valid(child_valid), .child_data(child_data),
    .child_ready(child_ready4), .up_valid(up_valid4), .up_ready(up_ready),
    .up_data(up_data4), .up_idx(up_idx4), .beat_cnt(beat_cnt4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    child_data[i*DW +: DW] = v;
  endtask

  task automatic chk_cnt(input int exp);
    chk("beat_cnt", 64'(beat_cnt), 64'(exp));
    chk("beat_cnt4", 64'(beat_cnt4), 64'((exp > 15) ? 15 : exp));
  endtask

  // Bench-side properties sampled mid-cycle.
  int          rst_evt = 0;
  int          prev_rst = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [IW-1:0] prev_idx = '0;

  always @(negedge rst_n) rst_evt++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot0", 64'($onehot0(child_ready)), 64'd1);
      if (up_valid) chk("idx_range", 64'(up_idx < IW'(NC)), 64'd1);
      if (prev_stall && prev_rst == rst_evt) begin
        chk("stall_data_stable", 64'(up_data), 64'(prev_data));
        chk("stall_idx_stable", 64'(up_idx), 64'(prev_idx));
      end
    end
    prev_stall = rst_n && up_valid && !up_ready;
    prev_data  = up_data;
    prev_idx   = up_idx;
    prev_rst   = rst_evt;
  end

  initial begin
    rst_n       = 1'b0;
    up_ready    = 1'b0;
    child_valid = '1;
    child_data  = '0;
    for (int i = 0; i < NC; i++) set_data(i, DW'(32'hA0 + i));
    #2;
    chk("rst_child_ready", 64'(child_ready), 64'd0);
    chk("rst_up_valid", 64'(up_valid), 64'd0);
    chk_cnt(0);

    // All children valid: round-robin 0..4, one beat per cycle.
    @(negedge clk);
    rst_n    = 1'b1;
    up_ready = 1'b1;
    #1;
    chk("first_ready", 64'(child_ready), 64'b00001);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rr_all_valid", 64'(up_valid), 64'd1);
      chk("rr_all_idx", 64'(up_idx), 64'(k % NC));
      chk("rr_all_data", 64'(up_data), 64'(32'hA0 + (k % NC)));
      chk_cnt(k);
    end
    step();
    chk_cnt(10);

    // Move pointer to 2, then only children 1 and 3 compete.
    child_valid = 5'b00010;
    step();
    chk("ptr_setup_idx", 64'(up_idx), 64'd1);
    child_valid = 5'b01010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sparse_idx", 64'(up_idx), (k % 2 == 0) ? 64'd3 : 64'd1);
      chk("sparse_data", 64'(up_data), (k % 2 == 0) ? 64'hA3 : 64'hA1);
      chk_cnt(12 + k);
    end

    // Stall with 0x11 from child 2 held upstream.
    child_valid = 5'b00100;
    set_data(2, 32'h11);
    step();
    chk("stall_load_idx", 64'(up_idx), 64'd2);
    up_ready    = 1'b0;
    child_valid = 5'b10100;
    set_data(2, 32'h22);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_ready", 64'(child_ready), 64'd0);
      step();
      chk("stall_valid", 64'(up_valid), 64'd1);
      chk("stall_idx", 64'(up_idx), 64'd2);
      chk("stall_data", 64'(up_data), 64'h11);
      chk_cnt(16);
    end
    up_ready = 1'b1;
    #1;
    chk("unstall_ready", 64'(child_ready), 64'b10000);
    step();
    chk("no_bubble_valid", 64'(up_valid), 64'd1);
    chk("no_bubble_idx", 64'(up_idx), 64'd4);
    chk("no_bubble_data", 64'(up_data), 64'hA4);
    chk_cnt(17);
    child_valid = '0;
    step();
    chk("drain_valid", 64'(up_valid), 64'd0);
    chk_cnt(18);

    // Reset while a beat is stalled upstream.
    child_valid = 5'b00100;
    step();
    chk("pre_rst_idx", 64'(up_idx), 64'd2);
    up_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(up_valid), 64'd0);
    chk("async_rst_idx", 64'(up_idx), 64'd0);
    chk("async_rst_data", 64'(up_data), 64'd0);
    chk("async_rst_ready", 64'(child_ready), 64'd0);
    chk_cnt(0);
    rst_n       = 1'b1;
    up_ready    = 1'b1;
    child_valid = 5'b00110;
    #1;
    chk("post_rst_ready", 64'(child_ready), 64'b00010);
    step();
    chk("post_rst_idx", 64'(up_idx), 64'd1);
    chk("post_rst_data", 64'(up_data), 64'hA1);

    // Long run to push the 4-bit counter into saturation.
    child_valid = '1;
    set_data(2, 32'hA2);
    for (int k = 0; k < 21; k++) step();
    chk_cnt(21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
